// File: rtl/tpc_result_pkg.sv
// rtl/tpc_result_pkg.sv - shared state enum, default sizes and SRAM bank/word mapping
package tpc_result_pkg;

  localparam int DEF_ARRAY_SIZE = 4;
  localparam int DEF_ACC_WIDTH  = 32;
  localparam int DEF_SRAM_WIDTH = 256;
  localparam int DEF_SRAM_DEPTH = 256;
  localparam int DEF_ADDR_WIDTH = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } wr_state_t;

  typedef struct packed {
    logic [1:0] bank;
    logic [7:0] word;
  } sram_loc_t;

  // Bank is XOR-swizzled with addr[9:8] so row strides of 256 do not pile onto one bank.
  function automatic sram_loc_t map_loc(input logic [9:0] addr);
    sram_loc_t loc;
    loc.bank = addr[1:0] ^ addr[9:8];
    loc.word = addr[9:2];
    return loc;
  endfunction

endpackage

// File: rtl/gemm_result_writer_if.sv
// rtl/gemm_result_writer_if.sv - config, accumulator-row and SRAM write channels
interface gemm_result_writer_if
  import tpc_result_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int SRAM_WIDTH = DEF_SRAM_WIDTH,
  parameter int SRAM_DEPTH = DEF_SRAM_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  localparam int WORD_WIDTH = $clog2(SRAM_DEPTH);

  logic                             cfg_valid;
  logic                             cfg_ready;
  logic [ADDR_WIDTH-1:0]            cfg_dst_addr;
  logic [15:0]                      cfg_rows;
  logic [4:0]                       cfg_shift;

  logic                             acc_valid;
  logic                             acc_ready;
  logic [ARRAY_SIZE*ACC_WIDTH-1:0]  acc_data;
  logic                             acc_last;

  logic                             sram_wr_en;
  logic                             sram_wr_ready;
  logic [ADDR_WIDTH-1:0]            sram_wr_addr;
  logic [1:0]                       sram_wr_bank;
  logic [WORD_WIDTH-1:0]            sram_wr_word;
  logic [SRAM_WIDTH-1:0]            sram_wr_data;

  modport master (
    output cfg_valid, cfg_dst_addr, cfg_rows, cfg_shift,
    output acc_valid, acc_data, acc_last,
    output sram_wr_ready,
    input  cfg_ready, acc_ready,
    input  sram_wr_en, sram_wr_addr, sram_wr_bank, sram_wr_word, sram_wr_data
  );

  modport slave (
    input  cfg_valid, cfg_dst_addr, cfg_rows, cfg_shift,
    input  acc_valid, acc_data, acc_last,
    input  sram_wr_ready,
    output cfg_ready, acc_ready,
    output sram_wr_en, sram_wr_addr, sram_wr_bank, sram_wr_word, sram_wr_data
  );

endinterface

// File: rtl/result_lane_quant.sv
// rtl/result_lane_quant.sv - one lane: arithmetic right shift then saturate to signed 8 bits
module result_lane_quant #(
  parameter int ACC_WIDTH = 32
) (
  input  logic [ACC_WIDTH-1:0] i_acc,
  input  logic [4:0]           i_shift,
  output logic [7:0]           o_q
);
  localparam logic signed [ACC_WIDTH-1:0] Q_MAX = 127;
  localparam logic signed [ACC_WIDTH-1:0] Q_MIN = -128;

  logic signed [ACC_WIDTH-1:0] w_shifted;

  assign w_shifted = $signed(i_acc) >>> i_shift;

  always_comb begin
    o_q = w_shifted[7:0];
    if (w_shifted > Q_MAX) begin
      o_q = 8'h7f;
    end else if (w_shifted < Q_MIN) begin
      o_q = 8'h80;
    end
  end

endmodule

// File: rtl/gemm_result_writer.sv
// rtl/gemm_result_writer.sv - writes accumulator rows to swizzled SRAM banks, one row per handshake
// Optional requantisation to int8 lanes is enabled by defining GEMM_RESULT_REQUANT_EN.
module gemm_result_writer
  import tpc_result_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int SRAM_WIDTH = DEF_SRAM_WIDTH,
  parameter int SRAM_DEPTH = DEF_SRAM_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  gemm_result_writer_if.slave bus,
  output logic                busy,
  output logic                done,
  output logic                error
);
  localparam int WORD_WIDTH = $clog2(SRAM_DEPTH);
  localparam int ACC_BITS   = ARRAY_SIZE * ACC_WIDTH;

  wr_state_t              r_state;
  wr_state_t              w_next;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [15:0]            r_rows;
  logic [15:0]            r_count;
  logic [15:0]            w_count_inc;
  logic                   w_final_row;
  logic [SRAM_WIDTH-1:0]  r_data;
  logic [SRAM_WIDTH-1:0]  w_packed;
  logic [ACC_BITS-1:0]    w_acc;
  logic                   r_last;
  logic                   r_error;
  sram_loc_t              w_loc;

  assign w_acc       = bus.acc_data;
  assign w_count_inc = r_count + 16'd1;
  assign w_final_row = (w_count_inc == r_rows);

`ifdef GEMM_RESULT_REQUANT_EN
  logic [4:0]              r_shift;
  logic [ARRAY_SIZE*8-1:0] w_q;

  for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
    result_lane_quant #(
      .ACC_WIDTH (ACC_WIDTH)
    ) u_quant (
      .i_acc   (w_acc[gi*ACC_WIDTH +: ACC_WIDTH]),
      .i_shift (r_shift),
      .o_q     (w_q[gi*8 +: 8])
    );
  end

  assign w_packed = SRAM_WIDTH'(w_q);
`else
  logic w_unused_shift;

  assign w_unused_shift = ^bus.cfg_shift;
  assign w_packed       = SRAM_WIDTH'(w_acc);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_rows  <= '0;
      r_count <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_error <= 1'b0;
`ifdef GEMM_RESULT_REQUANT_EN
      r_shift <= '0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (bus.cfg_valid) begin
            r_addr  <= bus.cfg_dst_addr;
            r_rows  <= bus.cfg_rows;
            r_count <= '0;
            r_error <= 1'b0;
`ifdef GEMM_RESULT_REQUANT_EN
            r_shift <= bus.cfg_shift;
`endif
          end
        end
        ACCEPT: begin
          if (bus.acc_valid) begin
            r_data <= w_packed;
            r_last <= bus.acc_last;
            // Flags both an early acc_last and a final row that arrives without one.
            if (bus.acc_last != w_final_row) begin
              r_error <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (bus.sram_wr_ready) begin
            r_addr  <= r_addr + ADDR_WIDTH'(1);
            r_count <= w_count_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next         = r_state;
    bus.cfg_ready  = 1'b0;
    bus.acc_ready  = 1'b0;
    bus.sram_wr_en = 1'b0;
    done           = 1'b0;
    case (r_state)
      IDLE: begin
        bus.cfg_ready = 1'b1;
        if (bus.cfg_valid) begin
          w_next = (bus.cfg_rows == 16'd0) ? FINISH : ACCEPT;
        end
      end
      ACCEPT: begin
        bus.acc_ready = 1'b1;
        if (bus.acc_valid) begin
          w_next = WRITE;
        end
      end
      WRITE: begin
        bus.sram_wr_en = 1'b1;
        if (bus.sram_wr_ready) begin
          w_next = (r_last || w_final_row) ? FINISH : ACCEPT;
        end
      end
      FINISH: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_loc            = map_loc(r_addr[9:0]);
  assign busy             = (r_state != IDLE);
  assign error            = r_error;
  assign bus.sram_wr_addr = r_addr;
  assign bus.sram_wr_bank = w_loc.bank;
  assign bus.sram_wr_word = WORD_WIDTH'(w_loc.word);
  assign bus.sram_wr_data = r_data;

endmodule

// File: tb/tb_gemm_result_writer.sv
// tb/tb_gemm_result_writer.sv - randomized self-checking bench with a behavioural write model
module tb_gemm_result_writer;

  localparam int AS  = 4;
  localparam int AW_ = 32;
  localparam int SW  = 256;
  localparam int SD  = 256;
  localparam int AW  = 20;

  typedef struct packed {
    logic [19:0]  addr;
    logic [1:0]   bank;
    logic [7:0]   word;
    logic [255:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic busy, done, error;

  wr_t  obs_q[$];
  wr_t  exp_q[$];
  int   obs_cyc[$];
  int   cyc = 0;
  int   done_cnt = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  bit   ready_rand = 1'b0;
  logic ready_val = 1'b1;
  int   cur_shift = 0;
  logic [127:0] fixed_lanes;
  bit   exp_err;
  int   job_done;

  always #5 clk = ~clk;

  gemm_result_writer_if #(.ARRAY_SIZE(AS), .ACC_WIDTH(AW_), .SRAM_WIDTH(SW),
                          .SRAM_DEPTH(SD), .ADDR_WIDTH(AW)) bus ();

  gemm_result_writer #(.ARRAY_SIZE(AS), .ACC_WIDTH(AW_), .SRAM_WIDTH(SW),
                       .SRAM_DEPTH(SD), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  always @(posedge clk) begin
    cyc++;
    if (!rst && bus.sram_wr_en && bus.sram_wr_ready) begin
      obs_q.push_back('{bus.sram_wr_addr, bus.sram_wr_bank, bus.sram_wr_word, bus.sram_wr_data});
      obs_cyc.push_back(cyc);
    end
    if (!rst && done) done_cnt++;
  end

  initial begin
    bus.sram_wr_ready = 1'b1;
    forever begin
      @(negedge clk);
      bus.sram_wr_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  // Reference: row k of a job lands at (dst + k) mod 2^20; data is each lane copied or requantised.
  function automatic logic [255:0] model_data(input logic [127:0] lanes);
    logic [255:0] r = '0;
    for (int i = 0; i < 4; i++) begin
`ifdef GEMM_RESULT_REQUANT_EN
      int v;
      v = int'($signed(lanes[i*32 +: 32])) >>> cur_shift;
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      r[i*8 +: 8] = 8'(v);
`else
      r[i*32 +: 32] = lanes[i*32 +: 32];
`endif
    end
    return r;
  endfunction

  function automatic wr_t model_wr(input logic [19:0] dst, input int k, input logic [127:0] lanes);
    wr_t w;
    int a;
    a = (int'(dst) + k) % (1 << 20);
    w.addr = 20'(a);
    w.bank = 2'((a % 4) ^ ((a / 256) % 4));
    w.word = 8'((a / 4) % 256);
    w.data = model_data(lanes);
    return w;
  endfunction

  task automatic send_cfg(input logic [19:0] dst, input int rows);
    @(negedge clk);
    bus.cfg_valid = 1'b1;
    bus.cfg_dst_addr = dst;
    bus.cfg_rows = 16'(rows);
    bus.cfg_shift = 5'(cur_shift);
    for (int n = 0; n < 50 && !bus.cfg_ready; n++) @(negedge clk);
    if (!bus.cfg_ready) begin
      total_cnt++;
      $display("FAIL cfg_timeout got cfg_ready=0 exp 1");
    end
    @(posedge clk);
    #1 bus.cfg_valid = 1'b0;
  endtask

  task automatic send_row(input logic [127:0] lanes, input bit last);
    @(negedge clk);
    bus.acc_valid = 1'b1;
    bus.acc_data = lanes;
    bus.acc_last = last;
    for (int n = 0; n < 100 && !bus.acc_ready; n++) @(negedge clk);
    if (!bus.acc_ready) begin
      total_cnt++;
      $display("FAIL acc_timeout got acc_ready=0 exp 1");
    end
    @(posedge clk);
    #1 bus.acc_valid = 1'b0;
    bus.acc_last = 1'b0;
  endtask

  task automatic drive_job(input logic [19:0] dst, input int rows, input int last_idx, input bit fixed);
    int nsend;
    int snap;
    logic [127:0] lanes;
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
    nsend = (rows == 0) ? 0 : ((last_idx >= 0 && last_idx < rows) ? last_idx + 1 : rows);
    exp_err = (rows > 0) && (last_idx != rows - 1);
    snap = done_cnt;
    send_cfg(dst, rows);
    for (int k = 0; k < nsend; k++) begin
      lanes = fixed ? fixed_lanes : {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(model_wr(dst, k, lanes));
      send_row(lanes, k == last_idx);
    end
    for (int n = 0; n < 200 && done_cnt == snap; n++) @(negedge clk);
    if (done_cnt == snap) begin
      total_cnt++;
      $display("FAIL done_timeout got no done pulse exp 1");
    end
    repeat (3) @(negedge clk);
    job_done = done_cnt - snap;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_dst_addr = '0;
    bus.cfg_rows = '0;
    bus.cfg_shift = '0;
    bus.acc_valid = 1'b0;
    bus.acc_data = '0;
    bus.acc_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({bus.cfg_ready, bus.acc_ready, bus.sram_wr_en, busy, done, error} !== 6'b100000)
      $display("FAIL reset_ctrl got %b exp 100000",
               {bus.cfg_ready, bus.acc_ready, bus.sram_wr_en, busy, done, error});
    else pass_cnt++;
    total_cnt++;
    if ({bus.sram_wr_addr, bus.sram_wr_bank, bus.sram_wr_word, bus.sram_wr_data} !== '0)
      $display("FAIL reset_bus got addr=%h data=%h exp 0", bus.sram_wr_addr, bus.sram_wr_data);
    else pass_cnt++;
  endtask

  task automatic test_identity();
    fixed_lanes = {4{32'd1}};
    cur_shift = 0;
    drive_job(20'h00020, 4, 3, 1'b1);
    total_cnt++;
    if (obs_q.size() !== 4) $display("FAIL ident_count got %0d exp 4", obs_q.size());
    else pass_cnt++;
    for (int k = 0; k < 4 && k < obs_q.size(); k++) begin
      total_cnt++;
      if (obs_q[k] !== exp_q[k]) $display("FAIL ident_wr%0d got %h exp %h", k, obs_q[k], exp_q[k]);
      else pass_cnt++;
      total_cnt++;
      if ({obs_q[k].addr, obs_q[k].bank, obs_q[k].word} !== {20'(32 + k), 2'(k), 8'd8})
        $display("FAIL ident_loc%0d got %h/%0d/%h exp %h/%0d/08", k,
                 obs_q[k].addr, obs_q[k].bank, obs_q[k].word, 32 + k, k);
      else pass_cnt++;
    end
    for (int k = 1; k < obs_cyc.size(); k++) begin
      total_cnt++;
      if (obs_cyc[k] - obs_cyc[k-1] !== 2)
        $display("FAIL ident_rate%0d got %0d exp 2", k, obs_cyc[k] - obs_cyc[k-1]);
      else pass_cnt++;
    end
    total_cnt++;
    if ({job_done, error} !== {32'd1, 1'b0}) $display("FAIL ident_done got done=%0d err=%b exp 1/0", job_done, error);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [127:0] lanes;
    wr_t exp_w;
    int snap;
    ready_val = 1'b0;
    repeat (2) @(negedge clk);
    obs_q.delete();
    lanes = {$urandom, $urandom, $urandom, $urandom};
    exp_w = model_wr(20'h12345, 0, lanes);
    snap = done_cnt;
    send_cfg(20'h12345, 1);
    send_row(lanes, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total_cnt++;
      if ({bus.sram_wr_en, bus.acc_ready, bus.sram_wr_addr, bus.sram_wr_data} !== {2'b10, exp_w.addr, exp_w.data})
        $display("FAIL bp_hold%0d got en=%b ar=%b addr=%h exp en=1 ar=0 addr=%h", k,
                 bus.sram_wr_en, bus.acc_ready, bus.sram_wr_addr, exp_w.addr);
      else pass_cnt++;
    end
    ready_val = 1'b1;
    for (int n = 0; n < 20 && done_cnt == snap; n++) @(negedge clk);
    total_cnt++;
    if (obs_q.size() !== 1 || done_cnt - snap !== 1)
      $display("FAIL bp_write got writes=%0d done=%0d exp 1/1", obs_q.size(), done_cnt - snap);
    else pass_cnt++;
    total_cnt++;
    if (obs_q.size() > 0 && obs_q[0] !== exp_w) $display("FAIL bp_data got %h exp %h", obs_q[0], exp_w);
    else pass_cnt++;
  endtask

  task automatic test_swizzle_wrap();
    drive_job(20'h001FF, 2, 1, 1'b0);
    total_cnt++;
    if (obs_q.size() !== 2) $display("FAIL swz_count got %0d exp 2", obs_q.size());
    else pass_cnt++;
    if (obs_q.size() == 2) begin
      total_cnt++;
      if ({obs_q[0].bank, obs_q[0].word, obs_q[1].bank, obs_q[1].word} !== {2'd2, 8'h7f, 2'd2, 8'h80})
        $display("FAIL swz_map got %0d/%h %0d/%h exp 2/7f 2/80",
                 obs_q[0].bank, obs_q[0].word, obs_q[1].bank, obs_q[1].word);
      else pass_cnt++;
      total_cnt++;
      if (obs_q[1] !== exp_q[1]) $display("FAIL swz_wr1 got %h exp %h", obs_q[1], exp_q[1]);
      else pass_cnt++;
    end
    drive_job(20'hFFFFF, 2, 1, 1'b0);
    total_cnt++;
    if (obs_q.size() !== 2 || obs_q[1].addr !== 20'h00000)
      $display("FAIL wrap_addr got n=%0d addr=%h exp 2/00000", obs_q.size(),
               obs_q.size() > 1 ? obs_q[1].addr : 20'hxxxxx);
    else pass_cnt++;
  endtask

  task automatic test_rows_zero();
    int snap;
    int done_at = -1;
    bit saw_en = 1'b0;
    obs_q.delete();
    snap = done_cnt;
    send_cfg(20'h00400, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (done && done_at < 0) done_at = k;
      if (bus.sram_wr_en) saw_en = 1'b1;
    end
    total_cnt++;
    if (done_cnt - snap !== 1 || !(done_at >= 1 && done_at <= 2))
      $display("FAIL zero_done got pulses=%0d at=%0d exp 1 within 2", done_cnt - snap, done_at);
    else pass_cnt++;
    total_cnt++;
    if (saw_en !== 1'b0 || obs_q.size() !== 0) $display("FAIL zero_nowrite got en=%b n=%0d exp 0/0", saw_en, obs_q.size());
    else pass_cnt++;
  endtask

  task automatic test_last_errors();
    drive_job(20'(($urandom)), 4, 1, 1'b0);
    total_cnt++;
    if ({32'(obs_q.size()), error, 32'(job_done)} !== {32'd2, 1'b1, 32'd1})
      $display("FAIL early_last got n=%0d err=%b done=%0d exp 2/1/1", obs_q.size(), error, job_done);
    else pass_cnt++;
    drive_job(20'(($urandom)), 3, -1, 1'b0);
    total_cnt++;
    if ({32'(obs_q.size()), error, 32'(job_done)} !== {32'd3, 1'b1, 32'd1})
      $display("FAIL missing_last got n=%0d err=%b done=%0d exp 3/1/1", obs_q.size(), error, job_done);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int rows;
    int last_idx;
    int sel;
    ready_rand = 1'b1;
    for (int j = 0; j < 8; j++) begin
      rows = $urandom_range(1, 5);
      sel = $urandom_range(0, 3);
      last_idx = (sel == 0) ? -1 : ((sel == 1) ? int'($urandom_range(0, rows - 1)) : rows - 1);
      cur_shift = $urandom_range(0, 31);
      drive_job(20'($urandom), rows, last_idx, 1'b0);
      total_cnt++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL rnd%0d_count got %0d exp %0d", j, obs_q.size(), exp_q.size());
      else pass_cnt++;
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
        total_cnt++;
        if (obs_q[k] !== exp_q[k]) $display("FAIL rnd%0d_wr%0d got %h exp %h", j, k, obs_q[k], exp_q[k]);
        else pass_cnt++;
      end
      total_cnt++;
      if ({error, 32'(job_done)} !== {exp_err, 32'd1})
        $display("FAIL rnd%0d_status got err=%b done=%0d exp %b/1", j, error, job_done, exp_err);
      else pass_cnt++;
    end
    ready_rand = 1'b0;
    ready_val = 1'b1;
    cur_shift = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    ready_val = 1'b0;
    repeat (2) @(negedge clk);
    obs_q.delete();
    send_cfg(20'h00777, 2);
    send_row({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    @(negedge clk);
    total_cnt++;
    if (bus.sram_wr_en !== 1'b1) $display("FAIL rstw_pre got en=%b exp 1", bus.sram_wr_en);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({bus.sram_wr_en, busy, bus.acc_ready, bus.cfg_ready, bus.sram_wr_addr, bus.sram_wr_data} !== {4'b0001, 276'd0})
      $display("FAIL rstw_out got en=%b busy=%b ar=%b cr=%b addr=%h exp 0/0/0/1/0",
               bus.sram_wr_en, busy, bus.acc_ready, bus.cfg_ready, bus.sram_wr_addr);
    else pass_cnt++;
    ready_val = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (obs_q.size() !== 0 || bus.sram_wr_en !== 1'b0)
      $display("FAIL rstw_drop got writes=%0d en=%b exp 0/0", obs_q.size(), bus.sram_wr_en);
    else pass_cnt++;
  endtask

`ifdef GEMM_RESULT_REQUANT_EN
  task automatic test_requant();
    logic [255:0] want;
    want = 256'h00000000_ff02807f;
    cur_shift = 1;
    fixed_lanes = {32'hffffffff, 32'd5, 32'hfffffed4, 32'd300};
    drive_job(20'h00040, 1, 0, 1'b1);
    total_cnt++;
    if (obs_q.size() !== 1 || obs_q[0].data !== want)
      $display("FAIL requant got n=%0d data=%h exp 1/%h", obs_q.size(),
               obs_q.size() > 0 ? obs_q[0].data : 256'hx, want);
    else pass_cnt++;
    cur_shift = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_identity();
    test_backpressure();
    test_swizzle_wrap();
    test_rows_zero();
    test_last_errors();
`ifdef GEMM_RESULT_REQUANT_EN
    test_requant();
`endif
    test_random();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
